// File: rtl/react_btn_deb_pkg.sv
// ----------------------------------------------------------------------------
// react_pkg
// Shared types and board constants for the reaction-tester button conditioner.
//   react_deb_state_t : debounce FSM states
//   REACT_CLK_HZ      : board clock frequency
//   REACT_DEB_CYCLES  : default debounce qualification time (20 ms at 50 MHz)
//   REACT_LONG_CYCLES : default long-press time (2 s at 50 MHz)
//   REACT_CNT_W       : default counter width, holds both cycle counts minus one
// ----------------------------------------------------------------------------
package react_pkg;

  localparam int REACT_CLK_HZ      = 50_000_000;
  localparam int REACT_DEB_CYCLES  = 1_000_000;
  localparam int REACT_LONG_CYCLES = 100_000_000;
  localparam int REACT_CNT_W       = 27;

  typedef enum logic [1:0] {
    S_IDLE,       // stable released
    S_PRESS_CHK,  // qualifying a press
    S_HELD,       // stable pressed
    S_REL_CHK     // qualifying a release
  } react_deb_state_t;

endpackage

// File: rtl/react_btn_deb_if.sv
// ----------------------------------------------------------------------------
// react_btn_deb_if
// Button-side bundle between the raw pin source and the debounced outputs.
//   btn       : raw asynchronous push-button, 1 = pressed
//   btn_level : debounced level, 1 = pressed
//   btn_rise  : one-cycle strobe on accepted press
//   btn_fall  : one-cycle strobe on accepted release
//   btn_long  : one-cycle strobe after a long accepted press
// master drives the raw pin and consumes the conditioned outputs;
// slave is the conditioner itself.
// ----------------------------------------------------------------------------
interface react_btn_deb_if;

  logic btn;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
  logic btn_long;

  modport master (
    output btn,
    input  btn_level, btn_rise, btn_fall, btn_long
  );

  modport slave (
    input  btn,
    output btn_level, btn_rise, btn_fall, btn_long
  );

endinterface

// File: rtl/react_sync2.sv
// ----------------------------------------------------------------------------
// react_sync2
// Generic two-flop synchroniser for asynchronous board inputs.
//   clk : system clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronised output, two clocks behind d
// ----------------------------------------------------------------------------
module react_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/react_btn_deb.sv
// ----------------------------------------------------------------------------
// react_btn_deb
// Push-button conditioner: synchronises the raw BTN0 pin, rejects contact
// bounce, and produces a clean level plus single-cycle rise/fall strobes.
// A change is accepted only after the synchronised input has been stable for
// DEB_CYCLES clocks; any glitch restarts qualification from zero.
//
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : react_btn_deb_if.slave (btn in; btn_level/rise/fall/long out)
//
// Optional feature, macro REACT_BTN_LONGPRESS_EN:
//   defined   - btn_long pulses once per press, LONG_CYCLES clocks after
//               btn_rise ("clear best time / restart" command)
//   undefined - btn_long is tied to 0 and no hold counter is built
// ----------------------------------------------------------------------------
module react_btn_deb
  import react_pkg::*;
#(
  parameter int DEB_CYCLES  = REACT_DEB_CYCLES,
  parameter int LONG_CYCLES = REACT_LONG_CYCLES,
  parameter int CNT_W       = REACT_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  react_btn_deb_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic s2;

  react_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn),
    .q   (s2)
  );

  react_deb_state_t state, state_d;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred; strobes default to 0 which also
  // makes them exactly one cycle wide.
  always_comb begin
    state_d   = state;
    deb_cnt_d = deb_cnt;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (s2) begin
          state_d   = S_PRESS_CHK;
          deb_cnt_d = '0;
        end
      end
      S_PRESS_CHK: begin
        if (!s2) begin
          state_d = S_IDLE;                 // bounce, drop the candidate press
        end else if (deb_cnt == DEB_LAST) begin
          state_d = S_HELD;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + 1'b1;       // bounded by the compare above
        end
      end
      S_HELD: begin
        if (!s2) begin
          state_d   = S_REL_CHK;
          deb_cnt_d = '0;
        end
      end
      S_REL_CHK: begin
        if (s2) begin
          state_d = S_HELD;                 // bounce, level stays pressed
        end else if (deb_cnt == DEB_LAST) begin
          state_d = S_IDLE;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      deb_cnt <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state   <= state_d;
      deb_cnt <= deb_cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;

`ifdef REACT_BTN_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             fired;
  logic             long_q;

  // hold_cnt counts clocks of accepted press (btn_level=1) and saturates at
  // LONG_LAST; fired keeps btn_long to a single pulse per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      fired    <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (fall_d) begin
        hold_cnt <= '0;
        fired    <= 1'b0;
      end else if (rise_d) begin
        hold_cnt <= '0;
      end else if (level_q) begin
        if (hold_cnt == LONG_LAST) begin
          if (!fired) begin
            long_q <= 1'b1;
            fired  <= 1'b1;
          end
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_react_btn_deb.sv
// ----------------------------------------------------------------------------
// tb_react_btn_deb
// Directed bench for react_btn_deb with DEB_CYCLES=4, LONG_CYCLES=20.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// "Edge k" counts rising edges after the stimulus change. Expected long-press
// behaviour follows REACT_BTN_LONGPRESS_EN as seen by this file.
// ----------------------------------------------------------------------------
module tb_react_btn_deb;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int CW   = 8;

`ifdef REACT_BTN_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  react_btn_deb_if b ();

  react_btn_deb #(
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Output vector order everywhere: {level, rise, fall, long}
  task automatic test_reset;
    logic [3:0] got;
    rst   = 1'b1;
    b.btn = 1'b0;
    tick;
    tick;
    got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 0000", got);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== 4'b0000) begin
        errors++;
        $display("FAIL idle_after_reset edge %0d: got %b expected 0000", k, got);
      end
    end
  endtask

  task automatic test_clean_press;
    logic [3:0] got, exp;
    b.btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_clean_release;
    logic [3:0] got, exp;
    b.btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp = {k < 7, 1'b0, k == 7, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL clean_release edge %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  // btn high for edges 1-3, low for edges 4-5, high from edge 6 onward.
  // The partial qualification is discarded; rise comes 7 edges after edge 6.
  task automatic test_bounce;
    logic [3:0] got, exp;
    for (int k = 1; k <= 14; k++) begin
      b.btn = !(k == 4 || k == 5);
      tick;
      exp = {k >= 12, k == 12, 1'b0, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce_press edge %0d: got %b expected %b", k, got, exp);
      end
    end
    b.btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp = {k < 7, 1'b0, k == 7, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL bounce_release edge %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  // Rise at edge 7, long at edge 7+LONG=27, then 20 more held edges with no
  // repeat, then release.
  task automatic test_long_press;
    logic [3:0] got, exp;
    b.btn = 1'b1;
    for (int k = 1; k <= 47; k++) begin
      tick;
      exp = {k >= 7, k == 7, 1'b0, LONG_EN && (k == 27)};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_press edge %0d: got %b expected %b", k, got, exp);
      end
    end
    b.btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp = {k < 7, 1'b0, k == 7, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL long_release edge %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_press;
    logic [3:0] got, exp;
    b.btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick;
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_reset_press edge %0d: got %b expected %b", k, got, exp);
      end
    end
    rst = 1'b1;
    tick;
    got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
    checks++;
    if (got !== 4'b0000) begin
      errors++;
      $display("FAIL mid_press_reset: got %b expected 0000", got);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp = {k >= 7, k == 7, 1'b0, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset_press edge %0d: got %b expected %b", k, got, exp);
      end
    end
    b.btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      exp = {k < 7, 1'b0, k == 7, 1'b0};
      got = {b.btn_level, b.btn_rise, b.btn_fall, b.btn_long};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL post_reset_release edge %0d: got %b expected %b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_clean_release();
    test_bounce();
    test_long_press();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/react_btn_deb.md
Name: react_btn_deb

Overview:
- Button conditioner between the raw BTN0 board pin and the reaction-tester core. The core is the LED control block and the reaction timer.
- Synchronises the asynchronous push-button and rejects contact bounce.
- Outputs a clean level plus single-cycle rise/fall strobes; the core uses these in place of the raw pin.
- Optional long-press strobe, intended as a "clear best time / restart" command.

Parameters:
- DEB_CYCLES, 1000000, cycles the synchronised input must stay stable before a change is accepted (20 ms at 50 MHz); legal range ≥2.
- LONG_CYCLES, 100000000, cycles of accepted press before btn_long fires (2 s at 50 MHz); must be > DEB_CYCLES.
- CNT_W, 27, counter width; must hold LONG_CYCLES-1 and DEB_CYCLES-1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn  input  1  raw asynchronous push-button, 1 = pressed
- btn_level  output  1  debounced button level, 1 = pressed
- btn_rise  output  1  one-cycle strobe when a press is accepted
- btn_fall  output  1  one-cycle strobe when a release is accepted
- btn_long  output  1  one-cycle strobe after LONG_CYCLES of accepted press (optional feature)

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - All flops are cleared on any rising clk edge with rst=1.
  - Reset values: btn_level=0, btn_rise=0, btn_fall=0, btn_long=0; sync stages=0; counters=0; state=S_IDLE.
- Synchroniser: 2-flop chain btn -> s1 -> s2. The FSM sees only s2.
- FSM states and transitions (deb_cnt is CNT_W bits):
  - S_IDLE (stable released): s2=1 -> S_PRESS_CHK, deb_cnt<=0.
  - S_PRESS_CHK:
    - s2=0 -> S_IDLE (bounce rejected, no strobe).
    - Else, if deb_cnt==DEB_CYCLES-1: -> S_HELD; btn_level<=1; btn_rise<=1 for one cycle; hold_cnt<=0.
    - Otherwise deb_cnt<=deb_cnt+1.
  - S_HELD (stable pressed): s2=0 -> S_REL_CHK, deb_cnt<=0.
  - S_REL_CHK:
    - s2=1 -> S_HELD (bounce rejected, btn_level stays 1, no strobe).
    - Else, if deb_cnt==DEB_CYCLES-1: -> S_IDLE; btn_level<=0; btn_fall<=1 for one cycle.
    - Otherwise deb_cnt<=deb_cnt+1.
- Outputs are registered. Strobes are high for exactly one cycle and are otherwise 0.
- Latency: with btn high from before edge 1 and held clean, the sequence is s2=1 after edge 2, S_PRESS_CHK after edge 3, btn_rise high in the cycle after edge DEB_CYCLES+3. Release is symmetric for btn_fall.
- Bounce shorter than DEB_CYCLES restarts the qualification with deb_cnt back to 0. No partial credit is kept.
- btn_rise and btn_fall can never be high in the same cycle. A minimum of DEB_CYCLES+1 cycles separates them.
- Reset mid-operation: outputs drop to 0 immediately with no btn_fall strobe. If the button is still held when rst deasserts, a fresh btn_rise follows after the full sync + debounce latency.
- Counters never wrap: deb_cnt is bounded by its compare; hold_cnt saturates.

Optional Feature:
- Macro REACT_BTN_LONGPRESS_EN.
- Defined:
  - hold_cnt (CNT_W bits) and a fired flag are present.
  - hold_cnt increments while btn_level=1 (S_HELD and S_REL_CHK).
  - When hold_cnt==LONG_CYCLES-1 and fired=0: btn_long<=1 for one cycle, fired<=1, hold_cnt holds.
  - hold_cnt and fired clear on btn_fall and on reset.
  - btn_long fires at most once per press, at the edge LONG_CYCLES after the btn_rise edge.
- Undefined: btn_long is tied to 0; hold_cnt and fired are not instantiated; all other behaviour is identical.

Decomposition:
- Package react_pkg:
  - State enum type react_deb_state_t (S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK).
  - Default constants REACT_DEB_CYCLES and REACT_LONG_CYCLES.
  - Board clock constant REACT_CLK_HZ=50000000.
- Sub-module react_sync2: generic 2-flop synchroniser (clk, rst, d, q), reusable for other board inputs.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=20, macro defined unless noted):
- Clean press: btn 0->1 before edge 1, held -> btn_rise high only in the cycle after edge 7; btn_level=1 from edge 7.
- Bounce reject: btn high for 3 cycles, low for 2, then high and held -> no strobe during the glitch; btn_rise fires 7 edges after the final rising of btn.
- Clean release after a press: btn 1->0 and held low -> btn_fall high for one cycle 7 edges later; btn_level=0; btn_long never fired because the press lasted under 20 cycles.
- Long press: held 40 cycles past btn_rise -> btn_long high exactly once, 20 edges after btn_rise; no repeat before btn_fall.
- Reset mid-press: rst=1 for 1 cycle while btn_level=1 and btn held -> all outputs 0 after the reset edge, no btn_fall; btn_rise fires again 7 edges after rst deasserts.
- Macro undefined, same long-press stimulus -> btn_long stays 0 throughout; rise/fall timing unchanged.
